// File: rtl/load_store_unit.sv
// RV32 load/store unit: one outstanding data-memory access, req/gnt then rvalid.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of masking.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      st;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        is_b, is_h, accept, trap;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_data;

  assign is_b     = func3[1:0] == 2'b00;
  assign is_h     = func3[1:0] == 2'b01;
  assign in_ready = st == IDLE;
  assign accept   = in_valid && (is_load ^ is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign off  = addr[1:0];
  assign trap = (is_h & addr[0]) | (func3[1] & |addr[1:0]);
`else
  // Without the trap, misaligned offsets snap down to natural alignment.
  assign off  = func3[1] ? 2'b00 : is_h ? {addr[1], 1'b0} : addr[1:0];
  assign trap = 1'b0;
`endif

  always_comb begin
    be = 4'b1111;
    wd = wdata;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << off;
        wd = {4{wdata[7:0]}};
      end
      is_h: begin
        be = 4'b0011 << off;
        wd = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lb      = dmem_rdata[{off_q, 3'b000} +: 8];
    lh      = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: ld_data = {{24{lb[7] & ~f3_q[2]}}, lb};
      f3_q[1:0] == 2'b01: ld_data = {{16{lh[15] & ~f3_q[2]}}, lh};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      ld_q       <= 1'b0;
      f3_q       <= 3'b0;
      off_q      <= 2'b0;
      rd_q       <= 5'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0;
      dmem_addr  <= 32'b0;
      dmem_wdata <= 32'b0;
      done       <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'b0;
      wb_data    <= 32'b0;
      misaligned <= 1'b0;
    end else begin
      done       <= 1'b0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
      unique case (st)
        IDLE: if (accept) begin
          ld_q       <= is_load;
          f3_q       <= func3;
          off_q      <= off;
          rd_q       <= rd;
          dmem_we    <= is_store;
          dmem_addr  <= {addr[31:2], 2'b00};
          dmem_wdata <= wd;
          if (trap) begin
            st         <= RESP;
            done       <= 1'b1;
            misaligned <= 1'b1;
          end else begin
            st       <= REQ;
            dmem_req <= 1'b1;
            dmem_be  <= be;
          end
        end
        REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          dmem_be  <= 4'b0;
          if (ld_q) begin
            st <= WAIT;
          end else begin
            st   <= RESP;
            done <= 1'b1;
          end
        end
        WAIT: if (dmem_rvalid) begin
          st      <= RESP;
          done    <= 1'b1;
          wb_we   <= 1'b1;
          wb_rd   <= rd_q;
          wb_data <= ld_data;
        end
        RESP: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, corner sequences,
// and random ops against a behavioural reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, is_load, is_store;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        done, wb_we, misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .wdata(wdata), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misaligned(misaligned)
  );

  typedef struct packed {
    logic [7:0]  lat;
    logic [7:0]  reqc;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        wbwe;
    logic        mis;
    logic [31:0] wbd;
    logic [4:0]  wbrd;
    logic        fin;
    logic        busy_bad;
    logic        after_ok;
  } res_t;

  typedef struct packed {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic [3:0]  gd;
    logic [3:0]  rvd;
    logic [3:0]  be;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [31:0] ewb;
    logic [7:0]  lat;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Drives one op from a negedge and plays the memory side; returns at the
  // negedge after done with the bench idle.
  task automatic run_op(input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input logic [4:0] rdi,
                        input int gd, input int rvd, output res_t r);
    int  seen, wn;
    bit  gr, fin;
    r = '0; seen = 0; wn = 0; gr = 0; fin = 0;
    in_valid = 1'b1; is_load = ld; is_store = !ld;
    func3 = f3; addr = a; wdata = wd; rd = rdi;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (done) begin
        r.lat = 8'(c); r.wbwe = wb_we; r.wbd = wb_data;
        r.wbrd = wb_rd; r.mis = misaligned; fin = 1;
      end else begin
        if (in_ready) r.busy_bad = 1'b1;
        if (dmem_req) begin
          seen++;
          r.be = dmem_be; r.a = dmem_addr; r.wd = dmem_wdata; r.we = dmem_we;
          if (seen > gd) begin dmem_gnt = 1'b1; gr = 1; end
        end else if (gr && ld) begin
          if (wn >= rvd) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
          wn++;
        end
      end
      @(negedge clk);
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    r.reqc = 8'(seen);
    r.fin = fin;
    r.after_ok = !done && !wb_we && !misaligned && in_ready;
  endtask

  // Reference: byte lanes and extraction from size/offset arithmetic.
  function automatic void model(input logic ld, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
      input int gd, input int rvd,
      output logic [3:0] be, output logic [31:0] ea, output logic [31:0] ewd,
      output logic [31:0] ewb, output int lat, output int reqc, output logic mis);
    int sz, o;
    logic [31:0] mask;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o = int'(a % 4);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (o % sz != 0) mis = 1'b1;
`else
    o = o - (o % sz);
`endif
    be   = 4'(((1 << sz) - 1) << o);
    ea   = a & ~32'h3;
    ewd  = (sz == 1) ? (wd & 32'hff) * 32'h01010101 :
           (sz == 2) ? (wd & 32'hffff) * 32'h00010001 : wd;
    mask = (sz == 4) ? 32'hffffffff : 32'((1 << (8 * sz)) - 1);
    ewb  = (rdat >> (8 * o)) & mask;
    if (sz < 4 && !f3[2] && ewb[8*sz-1]) ewb = ewb | ~mask;
    lat  = mis ? 1 : ld ? gd + rvd + 3 : gd + 2;
    reqc = mis ? 0 : gd + 1;
  endfunction

  vec_t tv[9];
  res_t r;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; is_load = 0; is_store = 0; func3 = 0;
    addr = 0; wdata = 0; rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_done", done, 0);
    chk("rst_wbwe", wb_we, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    //         ld f3    addr      wdata     rdata     gd rv be    eaddr     ewdata    ewb       lat
    tv[0] = '{1, 3'd2, 32'h100, 32'h0,      32'hDEADBEEF, 0, 0, 4'hF, 32'h100, 32'h0,      32'hDEADBEEF, 3};
    tv[1] = '{1, 3'd0, 32'h103, 32'h0,      32'h80FF0000, 0, 0, 4'h8, 32'h100, 32'h0,      32'hFFFFFF80, 3};
    tv[2] = '{1, 3'd4, 32'h103, 32'h0,      32'h80FF0000, 0, 0, 4'h8, 32'h100, 32'h0,      32'h00000080, 3};
    tv[3] = '{0, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,      4, 0, 4'hC, 32'h200, 32'hABCDABCD, 32'h0,      6};
    tv[4] = '{0, 3'd0, 32'h301, 32'h000000A5, 32'h0,      0, 0, 4'h2, 32'h300, 32'hA5A5A5A5, 32'h0,      2};
    tv[5] = '{1, 3'd1, 32'h402, 32'h0,      32'h80017FFF, 1, 2, 4'hC, 32'h400, 32'h0,      32'hFFFF8001, 6};
    tv[6] = '{1, 3'd5, 32'h400, 32'h0,      32'h8001F00D, 0, 1, 4'h3, 32'h400, 32'h0,      32'h0000F00D, 4};
    tv[7] = '{1, 3'd6, 32'h500, 32'h0,      32'h11223344, 2, 0, 4'hF, 32'h500, 32'h0,      32'h11223344, 5};
    tv[8] = '{0, 3'd7, 32'h600, 32'hCAFEF00D, 32'h0,      0, 0, 4'hF, 32'h600, 32'hCAFEF00D, 32'h0,      2};

    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].ld, tv[i].f3, tv[i].a, tv[i].wd, tv[i].rdat, 5'(i + 1),
             int'(tv[i].gd), int'(tv[i].rvd), r);
      chk($sformatf("v%0d_fin", i), r.fin, 1);
      chk($sformatf("v%0d_be", i), r.be, tv[i].be);
      chk($sformatf("v%0d_addr", i), r.a, tv[i].ea);
      chk($sformatf("v%0d_we", i), r.we, !tv[i].ld);
      chk($sformatf("v%0d_reqc", i), r.reqc, tv[i].gd + 1);
      chk($sformatf("v%0d_lat", i), r.lat, tv[i].lat);
      chk($sformatf("v%0d_wbwe", i), r.wbwe, tv[i].ld);
      chk($sformatf("v%0d_mis", i), r.mis, 0);
      chk($sformatf("v%0d_busy", i), r.busy_bad, 0);
      chk($sformatf("v%0d_after", i), r.after_ok, 1);
      if (tv[i].ld) begin
        chk($sformatf("v%0d_wbd", i), r.wbd, tv[i].ewb);
        chk($sformatf("v%0d_wbrd", i), r.wbrd, 5'(i + 1));
      end else begin
        chk($sformatf("v%0d_wdata", i), r.wd, tv[i].ewd);
      end
    end

    // Misaligned word load
    run_op(1, 3'd2, 32'h101, 32'h0, 32'h01020304, 5'd7, 0, 0, r);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_reqc", r.reqc, 0);
    chk("mis_flag", r.mis, 1);
    chk("mis_lat", r.lat, 1);
    chk("mis_wbwe", r.wbwe, 0);
`else
    chk("mis_addr", r.a, 32'h100);
    chk("mis_flag", r.mis, 0);
    chk("mis_be", r.be, 4'hF);
    chk("mis_wbd", r.wbd, 32'h01020304);
`endif

    // Illegal op encodings are never accepted
    in_valid = 1; is_load = 1; is_store = 1; addr = 32'h900; func3 = 3'd2;
    @(negedge clk); @(negedge clk);
    chk("ill_both_req", dmem_req, 0);
    chk("ill_both_rdy", in_ready, 1);
    is_load = 0; is_store = 0;
    @(negedge clk); @(negedge clk);
    chk("ill_none_req", dmem_req, 0);
    chk("ill_none_done", done, 0);
    in_valid = 0;
    @(negedge clk);

    // Back-to-back: in_valid held through the busy period
    in_valid = 1; is_load = 0; is_store = 1; func3 = 3'd2;
    addr = 32'h800; wdata = 32'h55;
    @(negedge clk);
    chk("b2b_rdy_c1", in_ready, 0);
    chk("b2b_req_c1", dmem_req, 1);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    chk("b2b_done_c2", done, 1);
    chk("b2b_rdy_c2", in_ready, 0);
    @(negedge clk);
    chk("b2b_rdy_c3", in_ready, 1);
    chk("b2b_done_c3", done, 0);
    @(negedge clk);
    in_valid = 0;
    chk("b2b_req2", dmem_req, 1);
    chk("b2b_addr2", dmem_addr, 32'h800);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    chk("b2b_done2", done, 1);
    @(negedge clk);
    chk("b2b_rdy_end", in_ready, 1);

    // Random ops against the reference model
    for (int k = 0; k < 60; k++) begin
      logic        ld, emis;
      logic [2:0]  f3;
      logic [31:0] a, wd, rdat, ea, ewd, ewb;
      logic [3:0]  ebe;
      logic [4:0]  rdi;
      int          gd, rvd, elat, ereqc;
      logic [2:0]  lf[5];
      logic [2:0]  sf[6];
      lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      sf = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      ld   = 1'($urandom_range(0, 1));
      f3   = ld ? lf[$urandom_range(0, 4)] : sf[$urandom_range(0, 5)];
      a    = $urandom;
      wd   = $urandom;
      rdat = $urandom;
      rdi  = 5'($urandom);
      gd   = $urandom_range(0, 3);
      rvd  = $urandom_range(0, 3);
      model(ld, f3, a, wd, rdat, gd, rvd, ebe, ea, ewd, ewb, elat, ereqc, emis);
      run_op(ld, f3, a, wd, rdat, rdi, gd, rvd, r);
      chk($sformatf("r%0d_fin", k), r.fin, 1);
      chk($sformatf("r%0d_lat", k), r.lat, 8'(elat));
      chk($sformatf("r%0d_reqc", k), r.reqc, 8'(ereqc));
      chk($sformatf("r%0d_mis", k), r.mis, emis);
      chk($sformatf("r%0d_wbwe", k), r.wbwe, ld && !emis);
      chk($sformatf("r%0d_after", k), r.after_ok, 1);
      if (!emis) begin
        chk($sformatf("r%0d_be", k), r.be, ebe);
        chk($sformatf("r%0d_addr", k), r.a, ea);
        chk($sformatf("r%0d_we", k), r.we, !ld);
        if (ld) begin
          chk($sformatf("r%0d_wbd", k), r.wbd, ewb);
          chk($sformatf("r%0d_wbrd", k), r.wbrd, rdi);
        end else begin
          chk($sformatf("r%0d_wdata", k), r.wd, ewd);
        end
      end
    end

    // Reset while waiting for rvalid; late rvalid must be dropped
    in_valid = 1; is_load = 1; is_store = 0; func3 = 3'd2; addr = 32'h700; rd = 5'd9;
    @(negedge clk);
    in_valid = 0;
    chk("rw_req", dmem_req, 1);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    rst_n = 0;
    #1;
    chk("rw_rst_req", dmem_req, 0);
    chk("rw_rst_be", dmem_be, 0);
    chk("rw_rst_wbd", wb_data, 0);
    chk("rw_rst_wbrd", wb_rd, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rvalid = 0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rw_done%0d", c), done, 0);
      chk($sformatf("rw_wbwe%0d", c), wb_we, 0);
      chk($sformatf("rw_rdy%0d", c), in_ready, 1);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
